// File: rtl/mem_line_xfer.sv
// Cache line transfer engine: writes back a victim line and/or fills a new line
// word by word over a request/acknowledge main-memory port.
module mem_line_xfer #(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    localparam int unsigned OFF           = $clog2(WORDS_PER_LINE)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_fill,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              cache_we,
    output logic [OFF-1:0]    word_idx,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    output logic              mm_rd,
    output logic              mm_wr,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic              mm_ack,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BASE_W = ADDR_W - OFF - 2;
    localparam logic [OFF-1:0] LastIdx = OFF'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [OFF-1:0]    idx_q, idx_d;
    logic [BASE_W-1:0] wb_base_q, wb_base_d;
    logic [BASE_W-1:0] fill_base_q, fill_base_d;
    logic              fill_pend_q, fill_pend_d;
    logic              last_word;

    // Byte offset within the line is irrelevant: transfers always cover the whole line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fill_addr[OFF+1:0], wb_addr[OFF+1:0]};

    assign last_word = (idx_q == LastIdx);
    assign word_idx  = idx_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            fill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            fill_pend_q <= fill_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        fill_pend_d = fill_pend_q;
        cache_wdata = '0;
        cache_we    = 1'b0;
        mm_addr     = '0;
        mm_wdata    = '0;
        mm_rd       = 1'b0;
        mm_wr       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_wb) begin
                    wb_base_d   = wb_addr[ADDR_W-1:OFF+2];
                    fill_base_d = fill_addr[ADDR_W-1:OFF+2];
                    fill_pend_d = req_fill;
                    idx_d       = '0;
                    state_d     = StWb;
                end else if (req_fill) begin
                    fill_base_d = fill_addr[ADDR_W-1:OFF+2];
                    idx_d       = '0;
                    state_d     = StFill;
                end
            end
            StWb: begin
                busy     = 1'b1;
                mm_wr    = 1'b1;
                mm_wdata = cache_rdata;
                mm_addr  = {wb_base_q, idx_q, 2'b00};
                if (mm_ack) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = fill_pend_q ? StFill : StDone;
                    end else begin
                        idx_d = idx_q + OFF'(1);
                    end
                end
            end
            StFill: begin
                busy        = 1'b1;
                mm_rd       = 1'b1;
                mm_addr     = {fill_base_q, idx_q, 2'b00};
                cache_we    = mm_ack;
                cache_wdata = mm_rdata;
                if (mm_ack) begin
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + OFF'(1);
                    end
                end
            end
            StDone: begin
                busy        = 1'b1;
                done        = 1'b1;
                fill_pend_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/mem_line_xfer.md
# mem_line_xfer

Line-transfer engine between the L1 cache arrays and main memory. It sits directly downstream of the cache control FSM. On a miss it writes back a dirty victim line and/or fills a new line word by word over a request/acknowledge main-memory port. It reports completion to the FSM with a single-cycle `done` pulse.

## Interface
- `WORDS_PER_LINE`, 8, words per cache line (power of two, ≥2); `OFF = log2(WORDS_PER_LINE)`
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, word width

- `CLK` in 1: sole clock, rising edge
- `RST` in 1: asynchronous, active-high reset
- `req_fill` in 1: fill requested; sampled only in IDLE
- `req_wb` in 1: writeback requested; sampled only in IDLE
- `fill_addr` in ADDR_W: any byte address in the line to fill
- `wb_addr` in ADDR_W: any byte address in the victim line
- `cache_rdata` in DATA_W: victim word at `word_idx`, combinational from the cache
- `cache_wdata` out DATA_W: fill word to the cache
- `cache_we` out 1: write `cache_wdata` to the cache at `word_idx`
- `word_idx` out OFF: word index within the line
- `mm_addr` out ADDR_W: main-memory word address
- `mm_wdata` out DATA_W: writeback data
- `mm_rd` out 1: read request, held until acknowledged
- `mm_wr` out 1: write request, held until acknowledged
- `mm_rdata` in DATA_W: read data, valid when `mm_ack` is high during a read
- `mm_ack` in 1: current request completed (1-cycle pulse)
- `busy` out 1: high in every state except IDLE
- `done` out 1: 1-cycle completion pulse

## Operation
- States: IDLE, WB, FILL, DONE.
- **IDLE:**
  - `req_wb`=1: latch both line bases, latch `fill_pend`=`req_fill`, set `word_idx`=0, go to WB.
  - Otherwise `req_fill`=1: latch `fill_addr` base, set `word_idx`=0, go to FILL.
  - Otherwise stay in IDLE.
- **Line base:** `addr[ADDR_W-1:OFF+2]`. Low bits of the input addresses are ignored.
- **`mm_addr`:** `{base, word_idx, 2'b00}`. Every other output is 0 in IDLE.
- **WB:**
  - `mm_wr`=1, `mm_wdata`=`cache_rdata`, base = victim base.
  - On `mm_ack`: `word_idx`++.
  - On `mm_ack` at the last word: `word_idx`←0, then go to FILL if `fill_pend`, else go to DONE.
- **FILL:**
  - `mm_rd`=1, base = fill base.
  - `cache_we` = `mm_ack`, combinationally, with `cache_wdata`=`mm_rdata`. `cache_we` is never high without `mm_ack`.
  - On `mm_ack`: `word_idx`++.
  - On `mm_ack` at the last word: go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Boundary cases:**
  - Requests while `busy` are ignored, not queued.
  - `mm_ack` in IDLE or DONE is ignored.
  - `word_idx` wraps to 0 only via the explicit last-word reset, never by overflow.
  - Input address changes after the start are ignored.
- **Reset:**
  - `RST` asserted at any time forces IDLE, `word_idx`=0, `fill_pend`=0, and all outputs 0.
  - An in-flight transfer is abandoned with no `done`. Partially filled cache words are the FSM's responsibility.

## Timing
- The request is sampled at rising edge E0. `busy`, and `mm_rd` or `mm_wr`, go high in the cycle after E0.
- A request is held, with constant `mm_addr` and `mm_wdata`, until the edge at which `mm_ack`=1. At that edge the next word's address is presented. `mm_rd`/`mm_wr` stay high across words with no idle gap.
- Minimum one cycle per word when `mm_ack` is permanently high.
- Latency from E0 to the `done` cycle is 1 + Σ(cycles per word). With zero wait states:
  - fill only: 8+1 cycles
  - writeback+fill: 16+1 cycles
- Between WB and FILL, `mm_wr` drops and `mm_rd` rises on the same edge. There is no dead cycle.
- `done` coincides with `busy`=1 in its cycle. `busy` falls the cycle after.

## Test plan
- **Fill, zero wait:**
  - Stimulus: `req_fill`=1, `fill_addr`=0x0000_1234, `mm_ack` tied 1, `mm_rdata`=0xA0+idx.
  - Response: `mm_addr` = 0x1220, 0x1224, …, 0x123C on consecutive cycles, 8 `cache_we` pulses with data 0xA0..0xA7, `done` in cycle 9.
- **Writeback then fill, wait states:**
  - Stimulus: `req_wb`=`req_fill`=1, `wb_addr`=0x400, `fill_addr`=0x800, `mm_ack` every 3rd cycle.
  - Response: 8 writes to 0x400..0x41C carrying `cache_rdata`, then 8 reads from 0x800..0x81C, `done` once, 48+1 cycles after the start.
- **Writeback only:**
  - Stimulus: `req_wb`=1, `req_fill`=0.
  - Response: 8 writes, no `mm_rd`, `cache_we` never asserted, then `done`.
- **Reset mid-fill:**
  - Stimulus: assert `RST` after the 3rd `mm_ack`, asynchronous to the clock.
  - Response: all outputs 0 immediately, no `done`. The next `req_fill` restarts at `word_idx` 0.
- **Requests while busy:**
  - Stimulus: pulse `req_fill` with a new address during FILL.
  - Response: ignored. The original address is completed, and after `done` the FSM returns to IDLE with no second transfer.
- **Spurious ack:**
  - Stimulus: `mm_ack`=1 in IDLE and in DONE.
  - Response: no state change, no `cache_we`, `word_idx` stays 0.
